// File: rtl/mem_wb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_wb_arbiter_pkg
// Shared definitions for the core-to-Wishbone request arbiter:
//   - state_t      : bus sequencer states (IDLE, BUS, RESP)
//   - ARB_FIXED/RR : arbitration mode selectors
//   - slice_lo     : low bit of port p's field inside a flat packed bus
//   - idx_width    : index width for a count of items (never below 1)
// -----------------------------------------------------------------------------
package mem_wb_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Port p's field of width w starts at bit p*w of the flattened bus.
  function automatic int slice_lo(input int port, input int width);
    return port * width;
  endfunction

  // Width of an index able to address n items; a single item still needs 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_wb_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational grant selection over NUM_PORTS requesters.
//   i_req        : request vector
//   i_ptr        : index of the last granted port (round-robin history)
//   i_rr_mode    : 0 = fixed priority (lowest index wins),
//                  1 = round-robin (search starts at i_ptr+1, wrapping)
//   o_gnt_valid  : at least one request present
//   o_gnt_onehot : one-hot grant
//   o_gnt_idx    : binary index of the granted port
// -----------------------------------------------------------------------------
module rr_arbiter
  import mem_wb_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int IDX_W     = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_ptr,
  input  logic                 i_rr_mode,
  output logic                 o_gnt_valid,
  output logic [NUM_PORTS-1:0] o_gnt_onehot,
  output logic [IDX_W-1:0]     o_gnt_idx
);

  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1'b1);

  logic [IDX_W-1:0] w_cand;

  // Port visited at search step 'step'; step 0 has the highest priority.
  function automatic logic [IDX_W-1:0] cand_of(input int step, input logic rr,
                                               input logic [IDX_W-1:0] ptr);
    int v;
    v = rr ? ((int'(ptr) + 1 + step) % NUM_PORTS) : step;
    return IDX_W'(v);
  endfunction

  // Walk the priority order from lowest to highest so the last hit is the winner.
  always_comb begin
    o_gnt_valid = 1'b0;
    o_gnt_idx   = '0;
    w_cand      = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      w_cand      = cand_of(i, i_rr_mode, i_ptr);
      o_gnt_idx   = i_req[w_cand] ? w_cand : o_gnt_idx;
      o_gnt_valid = o_gnt_valid | i_req[w_cand];
    end
    o_gnt_onehot = o_gnt_valid ? (ONE_HOT0 << o_gnt_idx) : '0;
  end

endmodule

// File: rtl/mem_wb_arbiter.sv
// -----------------------------------------------------------------------------
// mem_wb_arbiter
// Arbitrates NUM_PORTS core-side enable/valid memory channels onto a single
// Wishbone classic master. Requests are latched per port, granted with fixed
// or round-robin priority, and completed with a one-cycle valid pulse. A bus
// cycle that sees no ack for TIMEOUT_CYCLES cycles completes with an error.
//
// Ports:
//   clk_core, rst_core       : clock, synchronous active-high reset
//   port_en_i/we_i           : per-port request strobe / write enable
//   port_addr_i/wdata_i/wstrb_i : packed per-port request fields
//   port_valid_o/err_o       : per-port completion pulse / timeout flag
//   port_rdata_o             : read data, qualified by port_valid_o
//   wb_cyc_o/stb_o/we_o/wstrb_o/addr_o/data_o : Wishbone master outputs
//   wb_data_i, wb_ack_i      : Wishbone slave response
// -----------------------------------------------------------------------------
module mem_wb_arbiter
  import mem_wb_arbiter_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk_core,
  input  logic                             rst_core,
  input  logic [NUM_PORTS-1:0]             port_en_i,
  input  logic [NUM_PORTS-1:0]             port_we_i,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wdata_i,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_wstrb_i,
  output logic [NUM_PORTS-1:0]             port_valid_o,
  output logic [NUM_PORTS-1:0]             port_err_o,
  output logic [DATA_WIDTH-1:0]            port_rdata_o,
  output logic                             wb_cyc_o,
  output logic                             wb_stb_o,
  output logic                             wb_we_o,
  output logic [DATA_WIDTH/8-1:0]          wb_wstrb_o,
  output logic [ADDR_WIDTH-1:0]            wb_addr_o,
  output logic [DATA_WIDTH-1:0]            wb_data_o,
  input  logic [DATA_WIDTH-1:0]            wb_data_i,
  input  logic                             wb_ack_i
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = idx_width(NUM_PORTS);
  localparam int CNT_W  = idx_width(TIMEOUT_CYCLES + 1);

  localparam logic [NUM_PORTS-1:0] ONE_HOT0 = NUM_PORTS'(1'b1);
  localparam logic [IDX_W-1:0]     PTR_RST  = IDX_W'(NUM_PORTS - 1);
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic                 TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic                 RR_MODE  = (ARB_MODE == ARB_RR);

  // Sequencer state
  state_t r_state, w_state_nxt;

  // Per-port latched requests
  logic [NUM_PORTS-1:0]  r_pending, w_pending_nxt;
  logic [NUM_PORTS-1:0]  r_req_we, w_req_we_nxt;
  logic [ADDR_WIDTH-1:0] r_req_addr  [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] w_req_addr_nxt  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] r_req_wdata [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_req_wdata_nxt [NUM_PORTS];
  logic [STRB_W-1:0]     r_req_wstrb [NUM_PORTS];
  logic [STRB_W-1:0]     w_req_wstrb_nxt [NUM_PORTS];

  // Unpacked views of the flat input buses
  logic [ADDR_WIDTH-1:0] w_in_addr  [NUM_PORTS];
  logic [DATA_WIDTH-1:0] w_in_wdata [NUM_PORTS];
  logic [STRB_W-1:0]     w_in_wstrb [NUM_PORTS];

  // Arbitration bookkeeping
  logic [IDX_W-1:0] r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0] r_win, w_win_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // Registered outputs
  logic                  r_cyc, w_cyc_nxt;
  logic                  r_we, w_we_nxt;
  logic [STRB_W-1:0]     r_wstrb, w_wstrb_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
  logic [NUM_PORTS-1:0]  r_valid, w_valid_nxt;
  logic [NUM_PORTS-1:0]  r_perr, w_perr_nxt;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;

  // Combinational helpers
  logic [NUM_PORTS-1:0]  w_win_oh, w_busy, w_new, w_req_set;
  logic                  w_gnt_valid;
  logic [NUM_PORTS-1:0]  w_gnt_oh;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_tmo_hit;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [STRB_W-1:0]     w_sel_wstrb;

  // Split the packed per-port buses into arrays indexed by port number.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_in_addr[p]  = port_addr_i[slice_lo(p, ADDR_WIDTH) +: ADDR_WIDTH];
      w_in_wdata[p] = port_wdata_i[slice_lo(p, DATA_WIDTH) +: DATA_WIDTH];
      w_in_wstrb[p] = port_wstrb_i[slice_lo(p, STRB_W) +: STRB_W];
    end
  end

  // The port in service stays busy through BUS and RESP so a stray en cannot
  // re-latch it before its valid pulse.
  assign w_win_oh  = ONE_HOT0 << r_win;
  assign w_busy    = r_pending | ((r_state != ST_IDLE) ? w_win_oh : '0);
  assign w_new     = port_en_i & ~w_busy;
  assign w_req_set = r_pending | w_new;
  assign w_tmo_hit = TMO_EN && (r_cnt == CNT_LAST);

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .IDX_W     (IDX_W)
  ) u_arb (
    .i_req        (w_req_set),
    .i_ptr        (r_ptr),
    .i_rr_mode    (RR_MODE),
    .o_gnt_valid  (w_gnt_valid),
    .o_gnt_onehot (w_gnt_oh),
    .o_gnt_idx    (w_gnt_idx)
  );

  // A request arriving in the grant cycle is forwarded straight from the inputs.
  assign w_sel_we    = w_new[w_gnt_idx] ? port_we_i[w_gnt_idx]  : r_req_we[w_gnt_idx];
  assign w_sel_addr  = w_new[w_gnt_idx] ? w_in_addr[w_gnt_idx]  : r_req_addr[w_gnt_idx];
  assign w_sel_wdata = w_new[w_gnt_idx] ? w_in_wdata[w_gnt_idx] : r_req_wdata[w_gnt_idx];
  assign w_sel_wstrb = w_new[w_gnt_idx] ? w_in_wstrb[w_gnt_idx] : r_req_wstrb[w_gnt_idx];

  // State register and all datapath registers, with synchronous reset.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      r_state   <= ST_IDLE;
      r_pending <= '0;
      r_req_we  <= '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_req_addr[p]  <= '0;
        r_req_wdata[p] <= '0;
        r_req_wstrb[p] <= '0;
      end
      r_ptr   <= PTR_RST;
      r_win   <= '0;
      r_cnt   <= '0;
      r_cyc   <= 1'b0;
      r_we    <= 1'b0;
      r_wstrb <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_valid <= '0;
      r_perr  <= '0;
      r_rdata <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_req_we  <= w_req_we_nxt;
      for (int p = 0; p < NUM_PORTS; p++) begin
        r_req_addr[p]  <= w_req_addr_nxt[p];
        r_req_wdata[p] <= w_req_wdata_nxt[p];
        r_req_wstrb[p] <= w_req_wstrb_nxt[p];
      end
      r_ptr   <= w_ptr_nxt;
      r_win   <= w_win_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cyc   <= w_cyc_nxt;
      r_we    <= w_we_nxt;
      r_wstrb <= w_wstrb_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_valid <= w_valid_nxt;
      r_perr  <= w_perr_nxt;
      r_rdata <= w_rdata_nxt;
    end
  end

  // Next-state logic. RESP re-arbitrates so back-to-back grants lose one cycle only.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = w_gnt_valid ? ST_BUS : ST_IDLE;
      ST_BUS:  w_state_nxt = (wb_ack_i || w_tmo_hit) ? ST_RESP : ST_BUS;
      ST_RESP: w_state_nxt = w_gnt_valid ? ST_BUS : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    w_pending_nxt = r_pending | w_new;
    for (int p = 0; p < NUM_PORTS; p++) begin
      w_req_we_nxt[p]    = w_new[p] ? port_we_i[p]  : r_req_we[p];
      w_req_addr_nxt[p]  = w_new[p] ? w_in_addr[p]  : r_req_addr[p];
      w_req_wdata_nxt[p] = w_new[p] ? w_in_wdata[p] : r_req_wdata[p];
      w_req_wstrb_nxt[p] = w_new[p] ? w_in_wstrb[p] : r_req_wstrb[p];
    end
    w_ptr_nxt   = r_ptr;
    w_win_nxt   = r_win;
    w_cnt_nxt   = r_cnt;
    w_cyc_nxt   = r_cyc;
    w_we_nxt    = r_we;
    w_wstrb_nxt = r_wstrb;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_valid_nxt = '0;
    w_perr_nxt  = '0;
    w_rdata_nxt = r_rdata;

    case (r_state)
      ST_IDLE, ST_RESP: begin
        if (w_gnt_valid) begin
          w_win_nxt   = w_gnt_idx;
          w_ptr_nxt   = w_gnt_idx;
          w_cnt_nxt   = '0;
          w_cyc_nxt   = 1'b1;
          w_we_nxt    = w_sel_we;
          w_addr_nxt  = w_sel_addr;
          // Write-only fields are driven as zero on reads.
          w_wdata_nxt = w_sel_we ? w_sel_wdata : '0;
          w_wstrb_nxt = w_sel_we ? w_sel_wstrb : '0;
        end else begin
          w_cyc_nxt = 1'b0;
          w_cnt_nxt = '0;
        end
      end
      ST_BUS: begin
        if (wb_ack_i) begin
          w_cyc_nxt     = 1'b0;
          w_rdata_nxt   = r_we ? '0 : wb_data_i;
          w_valid_nxt   = w_win_oh;
          w_pending_nxt = (r_pending | w_new) & ~w_win_oh;
        end else if (w_tmo_hit) begin
          w_cyc_nxt     = 1'b0;
          w_rdata_nxt   = '0;
          w_valid_nxt   = w_win_oh;
          w_perr_nxt    = w_win_oh;
          w_pending_nxt = (r_pending | w_new) & ~w_win_oh;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_cyc_nxt = 1'b0;
      end
    endcase
  end

  assign port_valid_o = r_valid;
  assign port_err_o   = r_perr;
  assign port_rdata_o = r_rdata;
  assign wb_cyc_o     = r_cyc;
  assign wb_stb_o     = r_cyc;
  assign wb_we_o      = r_we;
  assign wb_wstrb_o   = r_wstrb;
  assign wb_addr_o    = r_addr;
  assign wb_data_o    = r_wdata;

endmodule

// File: tb/tb_mem_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_wb_arbiter
// Two instances: u_dut_a (2 ports, fixed priority, timeout 8) and
// u_dut_b (4 ports, round-robin, timeout 8). Inputs change on the falling
// edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_wb_arbiter;

  logic clk;
  logic rst;

  int n_tests;
  int n_fail;

  // ---------------- instance A: 2 ports, fixed priority ----------------
  logic [1:0]  a_en, a_we;
  logic [63:0] a_addr, a_wdata;
  logic [7:0]  a_wstrb;
  logic [1:0]  a_valid, a_err;
  logic [31:0] a_rdata;
  logic        a_cyc, a_stb, a_wwe;
  logic [3:0]  a_wstrb_o;
  logic [31:0] a_waddr, a_wdo, a_wdi;
  logic        a_ack, a_ack_en, a_stray;

  assign a_ack = (a_cyc & a_ack_en) | a_stray;

  mem_wb_arbiter #(
    .NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .ARB_MODE(0), .TIMEOUT_CYCLES(8)
  ) u_dut_a (
    .clk_core(clk), .rst_core(rst),
    .port_en_i(a_en), .port_we_i(a_we), .port_addr_i(a_addr),
    .port_wdata_i(a_wdata), .port_wstrb_i(a_wstrb),
    .port_valid_o(a_valid), .port_err_o(a_err), .port_rdata_o(a_rdata),
    .wb_cyc_o(a_cyc), .wb_stb_o(a_stb), .wb_we_o(a_wwe), .wb_wstrb_o(a_wstrb_o),
    .wb_addr_o(a_waddr), .wb_data_o(a_wdo), .wb_data_i(a_wdi), .wb_ack_i(a_ack)
  );

  // ---------------- instance B: 4 ports, round-robin ----------------
  logic [3:0]   b_en, b_we;
  logic [127:0] b_addr, b_wdata;
  logic [15:0]  b_wstrb;
  logic [3:0]   b_valid, b_err;
  logic [31:0]  b_rdata;
  logic         b_cyc, b_stb, b_wwe;
  logic [3:0]   b_wstrb_o;
  logic [31:0]  b_waddr, b_wdo, b_wdi;

  mem_wb_arbiter #(
    .NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
    .ARB_MODE(1), .TIMEOUT_CYCLES(8)
  ) u_dut_b (
    .clk_core(clk), .rst_core(rst),
    .port_en_i(b_en), .port_we_i(b_we), .port_addr_i(b_addr),
    .port_wdata_i(b_wdata), .port_wstrb_i(b_wstrb),
    .port_valid_o(b_valid), .port_err_o(b_err), .port_rdata_o(b_rdata),
    .wb_cyc_o(b_cyc), .wb_stb_o(b_stb), .wb_we_o(b_wwe), .wb_wstrb_o(b_wstrb_o),
    .wb_addr_o(b_waddr), .wb_data_o(b_wdo), .wb_data_i(b_wdi), .wb_ack_i(b_cyc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Safety net in case something stalls the sequence below.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_addr;
    int cnt;
    int gap;
    logic seen;

    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    a_en = 2'b00; a_we = 2'b00; a_addr = 64'd0; a_wdata = 64'd0; a_wstrb = 8'd0;
    a_wdi = 32'd0; a_ack_en = 1'b1; a_stray = 1'b0;
    b_en = 4'b0000; b_we = 4'b0000; b_wdata = 128'd0; b_wstrb = 16'd0; b_wdi = 32'd0;
    b_addr = {32'h0000_4000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};

    repeat (3) @(negedge clk);
    // ---- reset state ----
    check_eq("rst_cyc",   {62'd0, a_cyc, a_stb}, 64'd0);
    check_eq("rst_valid", {60'd0, a_valid, a_err}, 64'd0);
    check_eq("rst_rdata", a_rdata, 64'd0);
    check_eq("rst_addr",  a_waddr, 64'd0);
    check_eq("rst_b_cyc", b_cyc, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_cyc", a_cyc, 64'd0);

    // ---- 1: single read, zero-wait slave ----
    a_wdi = 32'hDEAD_BEEF;
    a_en = 2'b01; a_we = 2'b00; a_addr[31:0] = 32'h0000_0010;
    @(negedge clk);
    a_en = 2'b00;
    check_eq("t1_cyc",   a_cyc, 64'd1);
    check_eq("t1_stb",   a_stb, 64'd1);
    check_eq("t1_addr",  a_waddr, 64'h10);
    check_eq("t1_we",    {a_wwe, a_wstrb_o}, 64'd0);
    check_eq("t1_wdata", a_wdo, 64'd0);
    @(negedge clk);
    check_eq("t1_valid", a_valid, 64'd1);
    check_eq("t1_err",   a_err, 64'd0);
    check_eq("t1_rdata", a_rdata, 64'hDEAD_BEEF);
    check_eq("t1_cyc_off", a_cyc, 64'd0);
    @(negedge clk);
    check_eq("t1_valid_pulse", a_valid, 64'd0);

    // ---- 2: write on port 1 ----
    a_en = 2'b10; a_we = 2'b10;
    a_addr[63:32] = 32'h8000_0004; a_wdata[63:32] = 32'h1234_5678; a_wstrb[7:4] = 4'h3;
    @(negedge clk);
    a_en = 2'b00;
    check_eq("t2_cyc",   a_cyc, 64'd1);
    check_eq("t2_we",    a_wwe, 64'd1);
    check_eq("t2_wstrb", a_wstrb_o, 64'h3);
    check_eq("t2_wdata", a_wdo, 64'h1234_5678);
    check_eq("t2_addr",  a_waddr, 64'h8000_0004);
    @(negedge clk);
    check_eq("t2_valid", a_valid, 64'b10);
    check_eq("t2_rdata", a_rdata, 64'd0);
    check_eq("t2_err",   a_err, 64'd0);
    @(negedge clk);

    // ---- 3: fixed priority, both ports in one cycle ----
    a_we = 2'b00; a_addr = {32'h0000_0200, 32'h0000_0100};
    a_wdi = 32'hCAFE_0001;
    a_en = 2'b11;
    @(negedge clk);
    a_en = 2'b00;
    check_eq("t3_first_cyc",  a_cyc, 64'd1);
    check_eq("t3_first_addr", a_waddr, 64'h100);
    @(negedge clk);
    check_eq("t3_first_valid", a_valid, 64'b01);
    check_eq("t3_first_rdata", a_rdata, 64'hCAFE_0001);
    check_eq("t3_gap_cyc",     a_cyc, 64'd0);
    a_wdi = 32'hCAFE_0002;
    @(negedge clk);
    check_eq("t3_second_cyc",  a_cyc, 64'd1);
    check_eq("t3_second_addr", a_waddr, 64'h200);
    check_eq("t3_mid_valid",   a_valid, 64'd0);
    @(negedge clk);
    check_eq("t3_second_valid", a_valid, 64'b10);
    check_eq("t3_second_rdata", a_rdata, 64'hCAFE_0002);
    @(negedge clk);
    check_eq("t3_end_cyc", {62'd0, a_cyc, a_valid != 2'b00}, 64'd0);

    // ---- 4: round-robin, all four ports requesting continuously ----
    b_en = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      gap = 0;
      for (int w = 0; w < 8 && !b_cyc; w++) begin
        @(negedge clk);
        gap++;
      end
      exp_addr = 32'h0000_1000 * ((k % 4) + 1);
      check_eq($sformatf("t4_grant%0d_cyc", k), b_cyc, 64'd1);
      check_eq($sformatf("t4_grant%0d_addr", k), b_waddr, {32'd0, exp_addr});
      if (k > 0) check_eq($sformatf("t4_gap%0d", k), gap, 64'd1);
      @(negedge clk);
    end
    b_en = 4'b0000;
    repeat (12) @(negedge clk);
    check_eq("t4_drained", {59'd0, b_cyc, b_valid}, 64'd0);

    // ---- 5: timeout, slave never acks ----
    a_ack_en = 1'b0;
    a_wdi = 32'h5555_AAAA;
    a_addr[31:0] = 32'h0000_0300;
    a_en = 2'b01;
    @(negedge clk);
    a_en = 2'b00;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (a_cyc) begin
        cnt++;
        @(negedge clk);
      end
    end
    check_eq("t5_cyc_cycles", cnt, 64'd8);
    check_eq("t5_valid", a_valid, 64'b01);
    check_eq("t5_err",   a_err, 64'b01);
    check_eq("t5_rdata", a_rdata, 64'd0);
    a_stray = 1'b1;
    @(negedge clk);
    check_eq("t5_stray_valid", {60'd0, a_valid, a_err}, 64'd0);
    @(negedge clk);
    a_stray = 1'b0;
    check_eq("t5_stray_idle", {60'd0, a_cyc, a_valid, 1'b0}, 64'd0);
    @(negedge clk);
    check_eq("t5_after", a_valid, 64'd0);

    // ---- 6: reset while a bus cycle is open ----
    a_addr[63:32] = 32'h0000_0400;
    a_en = 2'b10;
    @(negedge clk);
    a_en = 2'b00;
    check_eq("t6_cyc_open", a_cyc, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t6_rst_cyc",   {62'd0, a_cyc, a_stb}, 64'd0);
    check_eq("t6_rst_valid", a_valid, 64'd0);
    rst = 1'b0;
    a_ack_en = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen = seen | (a_valid != 2'b00) | a_cyc;
    end
    check_eq("t6_no_resp", seen, 64'd0);
    a_wdi = 32'h600D_F00D;
    a_addr[31:0] = 32'h0000_0500;
    a_en = 2'b01;
    @(negedge clk);
    a_en = 2'b00;
    check_eq("t6_new_cyc",  a_cyc, 64'd1);
    check_eq("t6_new_addr", a_waddr, 64'h500);
    @(negedge clk);
    check_eq("t6_new_valid", a_valid, 64'b01);
    check_eq("t6_new_rdata", a_rdata, 64'h600D_F00D);
    check_eq("t6_new_err",   a_err, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
